pe_ws_param: RTL

Parametrised weight-stationary systolic-array processing element. It is the next generation of the array PE and runs on a single clock. It adds:
- a shadow/active double-buffered weight, loaded through a vertical shift chain
- valid-qualified activation and partial-sum flow
- a signed/unsigned arithmetic option
- optional saturation with a sticky overflow flag
- a bypass mode so the self-recovery logic can remove a faulty PE from the column without breaking the systolic pipeline.

---
 rtl/pe_pkg.sv | 28 ++
 rtl/pe_mac_unit.sv | 63 ++++++
 rtl/pe_ws_param.sv | 101 ++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared widths, arithmetic mode encodings and saturation constants for the
// weight-stationary PE family.
package pe_pkg;

  localparam int PE_AW = 8;
  localparam int PE_WW = 8;
  localparam int PE_PW = 24;

  typedef enum logic {
    ARITH_UNSIGNED = 1'b0,
    ARITH_SIGNED   = 1'b1
  } arith_mode_e;

  typedef enum logic {
    OVF_WRAP     = 1'b0,
    OVF_SATURATE = 1'b1
  } ovf_mode_e;

  // Bit patterns of the clamp limits for a pw-bit sum (pw <= 64); callers truncate.
  function automatic logic [63:0] satMaxPattern(input int pw, input bit sgn);
    return sgn ? (64'd1 << (pw - 1)) - 64'd1 : (64'd1 << pw) - 64'd1;
  endfunction

  function automatic logic [63:0] satMinPattern(input int pw, input bit sgn);
    return sgn ? (64'd1 << (pw - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply-accumulate for the PE: psum + ext(act * weight),
// with overflow detection and optional clamping.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int AW       = PE_AW,
  parameter int WW       = PE_WW,
  parameter int PW       = PE_PW,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic [AW-1:0] i_act,
  input  logic [WW-1:0] i_weight,
  input  logic [PW-1:0] i_psum,
  output logic [PW-1:0] o_result,
  output logic          o_ovf
);

  localparam int          PRW      = AW + WW;
  localparam arith_mode_e MODE     = arith_mode_e'(SIGNED);
  localparam ovf_mode_e   OVF_MODE = ovf_mode_e'(SATURATE);
  localparam logic [PW-1:0] SAT_MAX = PW'(satMaxPattern(PW, SIGNED));
  localparam logic [PW-1:0] SAT_MIN = PW'(satMinPattern(PW, SIGNED));

  logic signed [PRW-1:0] w_actS;
  logic signed [PRW-1:0] w_weightS;
  logic signed [PRW-1:0] w_prodS;
  logic        [PRW-1:0] w_prodU;
  logic signed [PW-1:0]  w_prodSExt;
  logic        [PW-1:0]  w_prodUExt;
  logic        [PW-1:0]  w_prodExt;
  logic        [PW:0]    w_sum;

  assign w_actS     = PRW'($signed(i_act));
  assign w_weightS  = PRW'($signed(i_weight));
  assign w_prodS    = w_actS * w_weightS;
  assign w_prodU    = PRW'(i_act) * PRW'(i_weight);
  assign w_prodSExt = PW'(w_prodS);
  assign w_prodUExt = PW'(w_prodU);
  assign w_prodExt  = (MODE == ARITH_SIGNED) ? w_prodSExt : w_prodUExt;

  // Signed overflow: both addends share a sign that the result does not.
  always_comb begin
    w_sum    = '0;
    o_ovf    = 1'b0;
    if (MODE == ARITH_SIGNED) begin
      w_sum = {i_psum[PW-1], i_psum} + {w_prodExt[PW-1], w_prodExt};
      o_ovf = (i_psum[PW-1] == w_prodExt[PW-1]) && (w_sum[PW-1] != i_psum[PW-1]);
    end else begin
      w_sum = {1'b0, i_psum} + {1'b0, w_prodExt};
      o_ovf = w_sum[PW];
    end
    o_result = w_sum[PW-1:0];
    if ((OVF_MODE == OVF_SATURATE) && o_ovf) begin
      if (MODE == ARITH_SIGNED) begin
        o_result = i_psum[PW-1] ? SAT_MIN : SAT_MAX;
      end else begin
        o_result = SAT_MAX;
      end
    end
  end

endmodule

// File: rtl/pe_ws_param.sv
// Weight-stationary systolic PE with double-buffered weight chain, valid-qualified
// dataflow, sticky overflow flag and a bypass path for fault isolation.
module pe_ws_param
  import pe_pkg::*;
#(
  parameter int AW       = PE_AW,
  parameter int WW       = PE_WW,
  parameter int PW       = PE_PW,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_load_en,
  input  logic [WW-1:0] weight_in,
  output logic [WW-1:0] weight_out,
  output logic          w_load_out,
  input  logic          w_swap,
  input  logic          act_valid_in,
  input  logic [AW-1:0] act_in,
  input  logic [PW-1:0] psum_in,
  output logic [AW-1:0] act_out,
  output logic          act_valid_out,
  output logic [PW-1:0] psum_out,
  input  logic          bypass,
  input  logic          ovf_clr,
  output logic          ovf_flag
);

  logic [WW-1:0] r_shadow;
  logic [WW-1:0] r_active;
  logic          r_wLoad;
  logic [AW-1:0] r_act;
  logic          r_valid;
  logic [PW-1:0] r_psum;
  logic          r_ovf;
  logic [PW-1:0] w_macResult;
  logic          w_macOvf;
  logic          w_ovfHit;

  pe_mac_unit #(
    .AW       (AW),
    .WW       (WW),
    .PW       (PW),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_mac (
    .i_act    (act_in),
    .i_weight (r_active),
    .i_psum   (psum_in),
    .o_result (w_macResult),
    .o_ovf    (w_macOvf)
  );

  // A swap captures the pre-edge shadow, so load and swap may coincide safely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_wLoad  <= 1'b0;
    end else begin
      r_wLoad <= w_load_en;
      if (w_load_en) r_shadow <= weight_in;
      if (w_swap)    r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act   <= '0;
      r_valid <= 1'b0;
      r_psum  <= '0;
    end else begin
      r_valid <= act_valid_in;
      if (act_valid_in) begin
        r_act  <= act_in;
        r_psum <= bypass ? psum_in : w_macResult;
      end
    end
  end

  assign w_ovfHit = act_valid_in & ~bypass & w_macOvf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovfHit) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign weight_out    = r_shadow;
  assign w_load_out    = r_wLoad;
  assign act_out       = r_act;
  assign act_valid_out = r_valid;
  assign psum_out      = r_psum;
  assign ovf_flag      = r_ovf;

endmodule
